// File: rtl/mem_access_unit_if.sv
// Data-bus request/acknowledge bundle between the MEM stage and the memory system.
// The master holds req/we/addr/wstrb/wdata until ack; rdata is valid only with ack.
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wstrb, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wstrb, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: decode, alignment check, one bus transaction, load formatting, LL/SC.
// Latency: 3 cycles in MEM minimum; o_mem_stall holds upstream until the bus acknowledges.
module mem_access_unit #(
    parameter logic [4:0] EXC_NONE = 5'h1F,
    parameter logic [4:0] EXC_ADEL = 5'd4,
    parameter logic [4:0] EXC_ADES = 5'd5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        i_MEM_current_instr,
    input  logic [31:0]        i_MEM_ALU_result,
    input  logic [31:0]        i_MEM_opr2_value,
    input  logic [4:0]         i_MEM_except_cause,
    input  logic               i_MEM_is_eret,
    input  logic               i_flush,
    mem_access_unit_if.master  dbus,
    output logic               o_mem_stall,
    output logic               o_MEM_load_valid,
    output logic [31:0]        o_MEM_load_data,
    output logic [4:0]         o_MEM_except_cause,
    output logic [31:0]        o_MEM_bad_vaddr,
    output logic               o_LL_bit
);
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_LL  = 6'h30;
    localparam logic [5:0] OP_SC  = 6'h38;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE, S_DRAIN} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_req;
    logic        r_we;
    logic [29:0] r_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic [5:0]  r_op;
    logic [1:0]  r_lane;
    logic [31:0] r_load_data;
    logic        r_ll;

    logic [5:0]  w_opc;
    logic [31:0] w_addr;
    logic [31:0] w_rt;
    logic        w_unused;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_misalign;
    logic        w_addr_err;
    logic        w_access;
    logic        w_is_sc;
    logic        w_sc_fail;
    logic        w_start;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_fmt;
    logic        w_ll_set;
    logic        w_ll_clr;

    assign w_opc    = i_MEM_current_instr[31:26];
    assign w_unused = ^i_MEM_current_instr[25:0];
    assign w_addr   = i_MEM_ALU_result;
    assign w_rt     = i_MEM_opr2_value;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_misalign = 1'b0;
        w_wstrb    = 4'h0;
        w_wdata    = 32'h0;
        case (w_opc)
            OP_LB, OP_LBU: w_is_load = 1'b1;
            OP_LH, OP_LHU: begin
                w_is_load  = 1'b1;
                w_misalign = w_addr[0];
            end
            OP_LW, OP_LL: begin
                w_is_load  = 1'b1;
                w_misalign = |w_addr[1:0];
            end
            OP_SB: begin
                w_is_store = 1'b1;
                w_wstrb    = 4'b0001 << w_addr[1:0];
                w_wdata    = {4{w_rt[7:0]}};
            end
            OP_SH: begin
                w_is_store = 1'b1;
                w_misalign = w_addr[0];
                w_wstrb    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{w_rt[15:0]}};
            end
            OP_SW, OP_SC: begin
                w_is_store = 1'b1;
                w_misalign = |w_addr[1:0];
                w_wstrb    = 4'hF;
                w_wdata    = w_rt;
            end
            default: ;
        endcase
    end

    // An incoming cause outranks our own address check; only self-detected errors report bad_vaddr.
    assign w_addr_err = (i_MEM_except_cause == EXC_NONE) && (w_is_load || w_is_store) && w_misalign;

    always_comb begin
        o_MEM_except_cause = EXC_NONE;
        o_MEM_bad_vaddr    = 32'h0;
        if (i_MEM_except_cause != EXC_NONE) begin
            o_MEM_except_cause = i_MEM_except_cause;
        end else if (w_addr_err) begin
            o_MEM_except_cause = w_is_load ? EXC_ADEL : EXC_ADES;
            o_MEM_bad_vaddr    = w_addr;
        end
    end

    assign w_access  = (w_is_load || w_is_store) && (o_MEM_except_cause == EXC_NONE);
    assign w_is_sc   = (w_opc == OP_SC);
    assign w_sc_fail = (r_state == S_IDLE) && w_access && w_is_sc && !r_ll && !i_flush && !reset;
    assign w_start   = (r_state == S_IDLE) && w_access && !(w_is_sc && !r_ll) && !i_flush && !reset;

    always_comb begin
        case (r_lane)
            2'd0:    w_byte = dbus.rdata[7:0];
            2'd1:    w_byte = dbus.rdata[15:8];
            2'd2:    w_byte = dbus.rdata[23:16];
            default: w_byte = dbus.rdata[31:24];
        endcase
        w_half = r_lane[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];
        w_fmt  = 32'h0;
        case (r_op)
            OP_LB:        w_fmt = {{24{w_byte[7]}}, w_byte};
            OP_LBU:       w_fmt = {24'h0, w_byte};
            OP_LH:        w_fmt = {{16{w_half[15]}}, w_half};
            OP_LHU:       w_fmt = {16'h0, w_half};
            OP_LW, OP_LL: w_fmt = dbus.rdata;
            OP_SC:        w_fmt = 32'd1;
            default:      w_fmt = 32'h0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_BUS;
            S_BUS: begin
                if (dbus.ack)    w_next = i_flush ? S_IDLE : S_DONE;
                else if (i_flush) w_next = S_DRAIN;
            end
            S_DONE:  w_next = S_IDLE;
            S_DRAIN: if (dbus.ack) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_ll_set = (r_state == S_DONE) && (r_op == OP_LL) && !i_flush;
    assign w_ll_clr = ((r_state == S_DONE) && (r_op == OP_SC)) || w_sc_fail ||
                      ((r_state == S_IDLE) && i_MEM_is_eret);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 30'h0;
            r_wstrb     <= 4'h0;
            r_wdata     <= 32'h0;
            r_op        <= 6'h0;
            r_lane      <= 2'h0;
            r_load_data <= 32'h0;
            r_ll        <= 1'b0;
        end else begin
            r_state <= w_next;
            r_req   <= (w_next == S_BUS) || (w_next == S_DRAIN);
            if (w_start) begin
                r_we    <= w_is_store;
                r_addr  <= w_addr[31:2];
                r_wstrb <= w_wstrb;
                r_wdata <= w_wdata;
                r_op    <= w_opc;
                r_lane  <= w_addr[1:0];
            end
            if ((r_state == S_BUS) && dbus.ack) begin
                r_load_data <= w_fmt;
            end
            // Clear wins over set when both land in the same cycle.
            if (w_ll_clr) begin
                r_ll <= 1'b0;
            end else if (w_ll_set) begin
                r_ll <= 1'b1;
            end
        end
    end

    assign dbus.req   = r_req;
    assign dbus.we    = r_we;
    assign dbus.addr  = {r_addr, 2'b00};
    assign dbus.wstrb = r_wstrb;
    assign dbus.wdata = r_wdata;

    assign o_mem_stall      = !reset && (w_start || (r_state == S_BUS) || (r_state == S_DRAIN));
    assign o_MEM_load_valid = ((r_state == S_DONE) && !i_flush) || w_sc_fail;
    assign o_MEM_load_data  = w_sc_fail ? 32'h0 : r_load_data;
    assign o_LL_bit         = r_ll;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of single ops plus LL/SC, ERET, flush and reset sequences.
module tb_mem_access_unit;
    localparam logic [4:0] NONE = 5'h1F;
    localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
    localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B, LL = 6'h30, SC = 6'h38;
    localparam int BUDGET = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr, alu, opr2;
    logic [4:0]  cause_in;
    logic        is_eret, flush;
    logic        stall, load_valid, ll_bit;
    logic [31:0] load_data, bad_vaddr;
    logic [4:0]  cause_out;

    mem_access_unit_if dbus_if ();

    mem_access_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .i_MEM_current_instr (instr),
        .i_MEM_ALU_result    (alu),
        .i_MEM_opr2_value    (opr2),
        .i_MEM_except_cause  (cause_in),
        .i_MEM_is_eret       (is_eret),
        .i_flush             (flush),
        .dbus                (dbus_if),
        .o_mem_stall         (stall),
        .o_MEM_load_valid    (load_valid),
        .o_MEM_load_data     (load_data),
        .o_MEM_except_cause  (cause_out),
        .o_MEM_bad_vaddr     (bad_vaddr),
        .o_LL_bit            (ll_bit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr, rt;
        logic [4:0]  cin;
        logic [31:0] rdata;
        int          ack_on;
        int          e_req, e_stall, e_valid;
        logic        chk_data;
        logic [31:0] e_data;
        logic        e_we;
        logic [31:0] e_daddr;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic [4:0]  e_cause;
        logic [31:0] e_bad;
    } vec_t;

    vec_t vecs[18];

    // Observations from the most recent run_op
    int          o_req, o_stall, o_valid;
    logic [31:0] o_data, o_daddr, o_wdata, o_bad;
    logic        o_we, o_stable;
    logic [3:0]  o_wstrb;
    logic [4:0]  o_cause;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Presents one op in MEM and acts as the bus until the pipeline advances.
    task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [4:0] cin, input logic [31:0] rdata,
                          input int ack_on, input int flush_on);
        int  c;
        bit  done;
        @(negedge clk);
        instr = {op, 26'h0}; alu = addr; opr2 = rt; cause_in = cin;
        o_req = 0; o_stall = 0; o_valid = 0; o_data = 32'h0; o_stable = 1'b1;
        o_we = 1'b0; o_daddr = 32'h0; o_wstrb = 4'h0; o_wdata = 32'h0;
        c = 0; done = 1'b0;
        while (!done && c < BUDGET) begin
            if (c > 0) @(negedge clk);
            dbus_if.ack = 1'b0; dbus_if.rdata = 32'h0; flush = 1'b0;
            if (dbus_if.req) begin
                o_req++;
                if (o_req == 1) begin
                    o_we = dbus_if.we; o_daddr = dbus_if.addr; o_wstrb = dbus_if.wstrb; o_wdata = dbus_if.wdata;
                end else if (dbus_if.we !== o_we || dbus_if.addr !== o_daddr ||
                             dbus_if.wstrb !== o_wstrb || dbus_if.wdata !== o_wdata) begin
                    o_stable = 1'b0;
                end
                if (o_req == flush_on) begin
                    flush = 1'b1; instr = 32'h0;
                end
                if (o_req == ack_on) begin
                    dbus_if.ack = 1'b1; dbus_if.rdata = rdata;
                end
            end
            #1;
            if (c == 0) begin
                o_cause = cause_out; o_bad = bad_vaddr;
            end
            if (stall) o_stall++;
            if (load_valid) begin
                o_valid++; o_data = load_data;
            end
            if (!stall) done = 1'b1;
            c++;
        end
        if (!done) chk("op_timeout", 32'(c), 32'(BUDGET + 1));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        instr = 32'h0; flush = 1'b0; is_eret = 1'b0;
        dbus_if.ack = 1'b0; dbus_if.rdata = 32'h0;
        #1;
    endtask

    initial begin
        reset = 1'b1; instr = 32'h0; alu = 32'h0; opr2 = 32'h0; cause_in = NONE;
        is_eret = 1'b0; flush = 1'b0; dbus_if.ack = 1'b0; dbus_if.rdata = 32'h0;

        //            op    addr        rt           cin   rdata        ack req stl val chk data          we daddr       wstrb  wdata         cause  bad
        vecs[0]  = '{SC,    32'h040, 32'h00000099, NONE, 32'h0,        0,  0,  0,  1, 1, 32'h00000000, 0, 32'h000, 4'h0, 32'h0,        NONE,  32'h0};
        vecs[1]  = '{LW,    32'h100, 32'h0,        NONE, 32'hDEADBEEF, 2,  2,  3,  1, 1, 32'hDEADBEEF, 0, 32'h100, 4'h0, 32'h0,        NONE,  32'h0};
        vecs[2]  = '{LB,    32'h103, 32'h0,        NONE, 32'h80112233, 1,  1,  2,  1, 1, 32'hFFFFFF80, 0, 32'h100, 4'h0, 32'h0,        NONE,  32'h0};
        vecs[3]  = '{LBU,   32'h103, 32'h0,        NONE, 32'h80112233, 1,  1,  2,  1, 1, 32'h00000080, 0, 32'h100, 4'h0, 32'h0,        NONE,  32'h0};
        vecs[4]  = '{LH,    32'h102, 32'h0,        NONE, 32'h80112233, 1,  1,  2,  1, 1, 32'hFFFF8011, 0, 32'h100, 4'h0, 32'h0,        NONE,  32'h0};
        vecs[5]  = '{LHU,   32'h100, 32'h0,        NONE, 32'h12348765, 3,  3,  4,  1, 1, 32'h00008765, 0, 32'h100, 4'h0, 32'h0,        NONE,  32'h0};
        vecs[6]  = '{LB,    32'h101, 32'h0,        NONE, 32'h44332211, 1,  1,  2,  1, 1, 32'h00000022, 0, 32'h100, 4'h0, 32'h0,        NONE,  32'h0};
        vecs[7]  = '{SH,    32'h202, 32'h1234ABCD, NONE, 32'h0,        1,  1,  2,  1, 0, 32'h0,        1, 32'h200, 4'hC, 32'hABCDABCD, NONE,  32'h0};
        vecs[8]  = '{SB,    32'h201, 32'h000000A5, NONE, 32'h0,        2,  2,  3,  1, 0, 32'h0,        1, 32'h200, 4'h2, 32'hA5A5A5A5, NONE,  32'h0};
        vecs[9]  = '{SW,    32'h300, 32'hCAFEF00D, NONE, 32'h0,        1,  1,  2,  1, 0, 32'h0,        1, 32'h300, 4'hF, 32'hCAFEF00D, NONE,  32'h0};
        vecs[10] = '{SB,    32'h203, 32'h00000012, NONE, 32'h0,        1,  1,  2,  1, 0, 32'h0,        1, 32'h200, 4'h8, 32'h12121212, NONE,  32'h0};
        vecs[11] = '{LW,    32'h101, 32'h0,        NONE, 32'h0,        0,  0,  0,  0, 0, 32'h0,        0, 32'h0,   4'h0, 32'h0,        5'd4,  32'h101};
        vecs[12] = '{SW,    32'h101, 32'h0,        NONE, 32'h0,        0,  0,  0,  0, 0, 32'h0,        0, 32'h0,   4'h0, 32'h0,        5'd5,  32'h101};
        vecs[13] = '{LH,    32'h103, 32'h0,        NONE, 32'h0,        0,  0,  0,  0, 0, 32'h0,        0, 32'h0,   4'h0, 32'h0,        5'd4,  32'h103};
        vecs[14] = '{SH,    32'h201, 32'h0,        NONE, 32'h0,        0,  0,  0,  0, 0, 32'h0,        0, 32'h0,   4'h0, 32'h0,        5'd5,  32'h201};
        vecs[15] = '{LW,    32'h101, 32'h0,        5'd10, 32'h0,       0,  0,  0,  0, 0, 32'h0,        0, 32'h0,   4'h0, 32'h0,        5'd10, 32'h0};
        vecs[16] = '{LW,    32'h100, 32'h0,        5'd8, 32'h0,        0,  0,  0,  0, 0, 32'h0,        0, 32'h0,   4'h0, 32'h0,        5'd8,  32'h0};
        vecs[17] = '{6'h0F, 32'h101, 32'h0,        NONE, 32'h0,        0,  0,  0,  0, 0, 32'h0,        0, 32'h0,   4'h0, 32'h0,        NONE,  32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_req",   32'(dbus_if.req),   32'h0);
        chk("rst_stall", 32'(stall),         32'h0);
        chk("rst_valid", 32'(load_valid),    32'h0);
        chk("rst_data",  load_data,          32'h0);
        chk("rst_cause", 32'(cause_out),     32'(NONE));
        chk("rst_ll",    32'(ll_bit),        32'h0);
        chk("rst_wstrb", 32'(dbus_if.wstrb), 32'h0);

        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].op, vecs[i].addr, vecs[i].rt, vecs[i].cin, vecs[i].rdata, vecs[i].ack_on, 0);
            chk($sformatf("v%0d_req", i),   32'(o_req),   32'(vecs[i].e_req));
            chk($sformatf("v%0d_stall", i), 32'(o_stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_valid", i), 32'(o_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_cause", i), 32'(o_cause), 32'(vecs[i].e_cause));
            chk($sformatf("v%0d_bad", i),   o_bad,        vecs[i].e_bad);
            if (vecs[i].chk_data)
                chk($sformatf("v%0d_data", i), o_data, vecs[i].e_data);
            if (vecs[i].e_req > 0) begin
                chk($sformatf("v%0d_we", i),     32'(o_we),     32'(vecs[i].e_we));
                chk($sformatf("v%0d_daddr", i),  o_daddr,       vecs[i].e_daddr);
                chk($sformatf("v%0d_wstrb", i),  32'(o_wstrb),  32'(vecs[i].e_wstrb));
                chk($sformatf("v%0d_stable", i), 32'(o_stable), 32'h1);
                if (vecs[i].e_we)
                    chk($sformatf("v%0d_wdata", i), o_wdata, vecs[i].e_wdata);
            end
        end

        // LL then SC succeeds, a second SC fails without touching the bus
        run_op(LL, 32'h40, 32'h0, NONE, 32'h00000055, 1, 0);
        chk("ll_req",  32'(o_req), 32'h1);
        chk("ll_data", o_data,     32'h55);
        idle_cycle();
        chk("ll_bit_set", 32'(ll_bit), 32'h1);
        run_op(SC, 32'h40, 32'h77, NONE, 32'hFFFFFFFF, 1, 0);
        chk("sc_req",   32'(o_req),   32'h1);
        chk("sc_we",    32'(o_we),    32'h1);
        chk("sc_wstrb", 32'(o_wstrb), 32'hF);
        chk("sc_wdata", o_wdata,      32'h77);
        chk("sc_valid", 32'(o_valid), 32'h1);
        chk("sc_data",  o_data,       32'h1);
        idle_cycle();
        chk("sc_ll_clr", 32'(ll_bit), 32'h0);
        run_op(SC, 32'h40, 32'h77, NONE, 32'h0, 1, 0);
        chk("sc2_req",   32'(o_req),   32'h0);
        chk("sc2_stall", 32'(o_stall), 32'h0);
        chk("sc2_valid", 32'(o_valid), 32'h1);
        chk("sc2_data",  o_data,       32'h0);

        // ERET while idle clears the LL bit
        run_op(LL, 32'h80, 32'h0, NONE, 32'h1, 1, 0);
        idle_cycle();
        chk("eret_ll_pre", 32'(ll_bit), 32'h1);
        @(negedge clk);
        is_eret = 1'b1;
        idle_cycle();
        chk("eret_ll_clr", 32'(ll_bit), 32'h0);

        // Flush during BUS: request held until the late ack, no load_valid
        run_op(LW, 32'h100, 32'h0, NONE, 32'h12345678, 5, 1);
        chk("flush_req",   32'(o_req),   32'h5);
        chk("flush_stall", 32'(o_stall), 32'h6);
        chk("flush_valid", 32'(o_valid), 32'h0);
        chk("flush_stab",  32'(o_stable), 32'h1);
        idle_cycle();
        chk("flush_idle_req", 32'(dbus_if.req), 32'h0);

        // Reset in BUS drops req and clears the LL bit
        run_op(LL, 32'h40, 32'h0, NONE, 32'h2, 1, 0);
        idle_cycle();
        chk("rst2_ll_pre", 32'(ll_bit), 32'h1);
        @(negedge clk);
        instr = {LW, 26'h0}; alu = 32'h100; cause_in = NONE;
        @(negedge clk);
        #1;
        chk("rst2_req_pre", 32'(dbus_if.req), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        instr = 32'h0;
        #1;
        chk("rst2_req",   32'(dbus_if.req), 32'h0);
        chk("rst2_stall", 32'(stall),       32'h0);
        chk("rst2_ll",    32'(ll_bit),      32'h0);
        reset = 1'b0;
        idle_cycle();
        chk("rst2_idle_req", 32'(dbus_if.req), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
